ebpc_encoder_ctrl: RTL
======================

Name: ebpc_encoder_ctrl

Overview:
Front-end sequencer of the EBPC encoder. It accepts the raw activation word stream and drives the zero/non-zero run-length encoder with one symbol per word (is_one = word != 0), asserting flush on the frame's last word. It also collects non-zero words into BLOCK_SIZE-word blocks for the bit-plane compressor, zero-pads the final partial block and tags it with flush. Its job is to keep both downstream datapaths consistent per frame under independent backpressure.

Parameters:
DATA_W, ebpc_pkg::DATA_W (8), width of one activation word
BLOCK_SIZE, ebpc_pkg::BLOCK_SIZE (8), non-zero words per BPC block

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
data_i  in  DATA_W  input activation word
last_i  in  1  data_i is the last word of the frame
vld_i  in  1  input valid
rdy_o  out  1  input ready
znz_is_one_o  out  1  symbol to ZRLE: 1 if data_i != 0
znz_flush_o  out  1  flush to ZRLE (= last_i of the transferred word)
znz_vld_o  out  1  symbol valid to ZRLE
znz_rdy_i  in  1  ZRLE ready
bpc_data_o  out  BLOCK_SIZE*DATA_W  block; word 0 in the MSB slice
bpc_flush_o  out  1  block is the frame's last block
bpc_vld_o  out  1  block valid
bpc_rdy_i  in  1  BPC ready
idle_o  out  1  RUN state, count 0, no vld_i

Behaviour:
- Reset: state RUN; cnt_q=0; buffer all 0. Outputs: rdy_o=0 unless the RUN conditions below hold; bpc_vld_o=0; bpc_flush_o=0; bpc_data_o=0; idle_o=1.
- nz = (data_i != 0). space_ok = !(nz && cnt_q == BLOCK_SIZE).
- Handshakes are valid/ready. vld outputs never depend on the matching rdy input. bpc_* outputs are registered. znz_* outputs are combinational from the input.
- RUN:
  - znz_vld_o = vld_i && space_ok.
  - rdy_o = znz_rdy_i && space_ok.
  - znz_is_one_o = nz; znz_flush_o = last_i.
  - Transfer when vld_i && rdy_o:
    - If nz: buf[cnt_q] <= data_i; cnt_q++.
    - If last_i: go to EMIT_LAST when cnt_d > 0; otherwise stay in RUN (an all-zero frame produces no BPC transaction).
  - If vld_i && !space_ok: go to EMIT_FULL. No transfer, and the ZRLE sees no symbol.
- EMIT_FULL:
  - bpc_vld_o=1, bpc_flush_o=0, rdy_o=0, znz_vld_o=0.
  - On bpc_rdy_i: buffer <= 0, cnt_q <= 0, go to RUN. The pending word is accepted in a later RUN cycle.
- EMIT_LAST:
  - bpc_vld_o=1, bpc_flush_o=1. Slices cnt_q..BLOCK_SIZE-1 are 0 (guaranteed by the buffer clear). rdy_o=0.
  - On bpc_rdy_i: clear buffer and count, go to RUN.
- A full block is deliberately held until the next non-zero word or end of frame. This guarantees the last BPC block of a frame always carries flush.
- A non-zero last word arriving with a full buffer goes EMIT_FULL, then RUN (accept), then EMIT_LAST.
- A zero word arriving with a full buffer is accepted normally. If it is last, the full block goes out via EMIT_LAST with flush=1.
- cnt_q width is $clog2(BLOCK_SIZE+1). It never exceeds BLOCK_SIZE; an assertion fires on overflow.
- While in an EMIT state, bpc_data_o and bpc_flush_o stay stable until bpc_rdy_i.
- Reset mid-frame discards the partial block and count. The downstream ZRLE is reset by the same rst_ni.

Decomposition:
- ebpc_pkg holds DATA_W, BLOCK_SIZE and ctrl_state_t {RUN, EMIT_FULL, EMIT_LAST}.
- The block buffer with count, write and clear is a natural sub-module: ebpc_block_buf.
- The FSM stays in ebpc_encoder_ctrl.

Test Plan:
1. Frame of 16 words of 0x00, last on word 16, all ready high -> 16 ZRLE symbols is_one=0, flush only on the 16th; bpc_vld_o never high; 16 input transfers in 16 cycles.
2. Frame 0x01..0x08, last on 0x08 -> 8 symbols is_one=1; then one block 0x0102030405060708 with flush=1; idle_o=1 afterwards.
3. Frame 0x01..0x09, last on 0x09 -> rdy_o drops when 0x09 is presented; block 0x01..0x08 with flush=0; then 0x09 accepted; block 0x0900000000000000 with flush=1.
4. Frame 00,05,00,00,07(last) -> is_one sequence 0,1,0,0,1 with flush on the 5th; block 0x0507000000000000 with flush=1.
5. Backpressure: znz_rdy_i low for 3 cycles mid-frame -> rdy_o low, no symbol lost or duplicated. bpc_rdy_i low for 5 cycles in EMIT_LAST -> bpc_data_o stable and rdy_o=0 throughout.
6. Reset after 3 non-zero words -> bpc_vld_o=0 and cnt_q=0. The next frame 0x0A(last) yields block 0x0A00000000000000 with flush=1.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared parameters and state encoding for the EBPC encoder front-end.
package ebpc_pkg;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BLOCK_SIZE = 8;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EMIT_FULL = 2'd1,
    EMIT_LAST = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/ebpc_block_buf.sv
// Collects non-zero words into one block; word 0 sits in the MSB slice.
module ebpc_block_buf import ebpc_pkg::*; #(
  parameter int unsigned DATA_W     = ebpc_pkg::DATA_W,
  parameter int unsigned BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE,
  parameter int unsigned CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         clr,
  output logic [CNT_W-1:0]             cnt,
  output logic [BLOCK_SIZE*DATA_W-1:0] data
);

  logic [0:BLOCK_SIZE-1][DATA_W-1:0] blk_q;
  logic [CNT_W-1:0]                  cnt_q;

  // Clearing to zero is what pads a partial final block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      blk_q <= '0;
      cnt_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
        if (cnt_q == CNT_W'(i)) begin
          blk_q[i] <= wr_data;
        end
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign data = blk_q;

  ebpc_block_buf_chk #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cnt    (cnt_q),
    .wr_en  (wr_en),
    .clr    (clr)
  );

endmodule

// File: rtl/ebpc_block_buf_chk.sv
// Property checker for the block buffer fill count.
module ebpc_block_buf_chk import ebpc_pkg::*; #(
  parameter int unsigned BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE,
  parameter int unsigned CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic [CNT_W-1:0] cnt,
  input logic             wr_en,
  input logic             clr
);

  // Count never passes the block size, and a full buffer is never written.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (cnt <= CNT_W'(BLOCK_SIZE))
        else $error("block count overflow: %0d", cnt);
      assert (!(wr_en && !clr && cnt == CNT_W'(BLOCK_SIZE)))
        else $error("write into full block buffer");
    end
  end

endmodule

// File: rtl/ebpc_encoder_ctrl.sv
// EBPC front-end sequencer: feeds the ZRLE one symbol per word and the BPC
// one block per BLOCK_SIZE non-zero words, keeping both aligned per frame.
module ebpc_encoder_ctrl import ebpc_pkg::*; #(
  parameter int unsigned DATA_W     = ebpc_pkg::DATA_W,
  parameter int unsigned BLOCK_SIZE = ebpc_pkg::BLOCK_SIZE
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         last_i,
  input  logic                         vld_i,
  output logic                         rdy_o,
  output logic                         znz_is_one_o,
  output logic                         znz_flush_o,
  output logic                         znz_vld_o,
  input  logic                         znz_rdy_i,
  output logic [BLOCK_SIZE*DATA_W-1:0] bpc_data_o,
  output logic                         bpc_flush_o,
  output logic                         bpc_vld_o,
  input  logic                         bpc_rdy_i,
  output logic                         idle_o
);

  localparam int unsigned CNT_W = $clog2(BLOCK_SIZE + 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nz, space_ok;
  logic             wr_en, clr;
  logic             rdy_s, znz_vld_s;
  logic             bpc_vld_q, bpc_flush_q;

  assign nz       = (data_i != '0);
  assign space_ok = !(nz && cnt_q == CNT_W'(BLOCK_SIZE));
  assign cnt_d    = cnt_q + CNT_W'(nz);

  // Next state, handshakes and buffer control.
  always_comb begin
    state_d   = state_q;
    rdy_s     = 1'b0;
    znz_vld_s = 1'b0;
    wr_en     = 1'b0;
    clr       = 1'b0;
    case (state_q)
      RUN: begin
        znz_vld_s = vld_i && space_ok;
        rdy_s     = znz_rdy_i && space_ok;
        if (vld_i && rdy_s) begin
          wr_en = nz;
          if (last_i && cnt_d != '0) begin
            state_d = EMIT_LAST;
          end else begin
            state_d = RUN;
          end
        end else if (vld_i && !space_ok) begin
          // Full block is released only once another non-zero word needs room.
          state_d = EMIT_FULL;
        end else begin
          state_d = RUN;
        end
      end
      EMIT_FULL, EMIT_LAST: begin
        if (bpc_rdy_i) begin
          clr     = 1'b1;
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State plus registered BPC handshake flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      bpc_vld_q   <= 1'b0;
      bpc_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bpc_vld_q   <= (state_d != RUN);
      bpc_flush_q <= (state_d == EMIT_LAST);
    end
  end

  ebpc_block_buf #(
    .DATA_W     (DATA_W),
    .BLOCK_SIZE (BLOCK_SIZE),
    .CNT_W      (CNT_W)
  ) u_block_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wr_en   (wr_en),
    .wr_data (data_i),
    .clr     (clr),
    .cnt     (cnt_q),
    .data    (bpc_data_o)
  );

  assign rdy_o        = rdy_s;
  assign znz_vld_o    = znz_vld_s;
  assign znz_is_one_o = nz;
  assign znz_flush_o  = last_i;
  assign bpc_vld_o    = bpc_vld_q;
  assign bpc_flush_o  = bpc_flush_q;
  assign idle_o       = (state_q == RUN) && (cnt_q == '0) && !vld_i;

endmodule
